// File: rtl/op3_pkg.sv
// Shared definitions for the three-operand sequencer: FSM states and
// width constants used by the top level and the result buffer.
package op3_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DONE_W     = 8;
    localparam int SETTLE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE
    } state_t;

endpackage

// File: rtl/op3_result_fifo.sv
// Small FIFO that holds function-unit results until the consumer takes them.
// Pointers wrap modulo FIFO_DEPTH, so any depth (not only powers of two) works.
module op3_result_fifo #(
    parameter int  DATA_W     = 4,
    parameter int  FIFO_DEPTH = 2,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is not reset; dout is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/op3_sequencer.sv
// Drives one operand triple at a time into an external combinational unit,
// waits SETTLE_CYC cycles, captures its result and queues it for the consumer.
module op3_sequencer
    import op3_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SETTLE_CYC = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    output logic [DATA_W-1:0] fu_a,
    output logic [DATA_W-1:0] fu_b,
    output logic [DATA_W-1:0] fu_c,
    input  logic [DATA_W-1:0] fu_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              busy,
    output logic [DONE_W-1:0] done_cnt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t              state;
    state_t              state_next;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [SETTLE_W-1:0] settle_next;
    logic                accept;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                full_unused;
    logic [CNT_W-1:0]    fifo_count;

    assign in_ready  = rst_n && (state == ST_IDLE) && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign busy      = (state != ST_IDLE);

    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        accept      = 1'b0;
        push        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    accept      = 1'b1;
                    settle_next = SETTLE_W'(SETTLE_CYC - 1);
                    state_next  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_next = ST_CAPTURE;
                end else begin
                    settle_next = settle_cnt - SETTLE_W'(1);
                end
            end
            ST_CAPTURE: begin
                push       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            fu_a       <= '0;
            fu_b       <= '0;
            fu_c       <= '0;
            done_cnt   <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_next;
            if (accept) begin
                fu_a <= in_a;
                fu_b <= in_b;
                fu_c <= in_c;
            end
            if (pop) begin
                done_cnt <= done_cnt + DONE_W'(1);
            end
        end
    end

    op3_result_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (fu_y),
        .dout  (out_y),
        .full  (full_unused),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_op3_sequencer.sv
// Self-checking bench for op3_sequencer with an XOR function unit model.
// Directed vectors and corner sequences, then randomized traffic against a reference model.
module tb_op3_sequencer;

    localparam int W      = 4;
    localparam int SETTLE = 2;
    localparam int DEPTH  = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b, in_c;
    logic [W-1:0] fu_a, fu_b, fu_c;
    logic [W-1:0] fu_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic         busy;
    logic [7:0]   done_cnt;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_done;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] y;
    } vec_t;

    vec_t vecs [6];

    op3_sequencer #(
        .DATA_W     (W),
        .SETTLE_CYC (SETTLE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_c      (fu_c),
        .fu_y      (fu_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    // External function unit.
    assign fu_y = fu_a ^ fu_b ^ fu_c;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offer a triple and return at #1 after the accepting edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_c = c;
        for (int i = 0; i < 32 && !in_ready; i++) tick();
        check("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_done++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        tick();
        exp_done = '0;
    endtask

    // Reference model state for the random phase.
    logic [W-1:0] m_q [$];
    bit           m_inflight;
    int           m_rem;
    logic [W-1:0] m_a, m_b, m_c, m_y;
    logic [7:0]   m_done;

    initial begin
        vecs[0] = '{a: 4'b1010, b: 4'b0100, c: 4'b0111, y: 4'b1001};
        vecs[1] = '{a: 4'b0000, b: 4'b0000, c: 4'b0000, y: 4'b0000};
        vecs[2] = '{a: 4'b1111, b: 4'b1111, c: 4'b1111, y: 4'b1111};
        vecs[3] = '{a: 4'b1111, b: 4'b0000, c: 4'b0000, y: 4'b1111};
        vecs[4] = '{a: 4'b0001, b: 4'b0010, c: 4'b0100, y: 4'b0111};
        vecs[5] = '{a: 4'b0101, b: 4'b0101, c: 4'b0011, y: 4'b0011};

        rst_n = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_c = '0;
        out_ready = 1'b0;
        exp_done = '0;
        #2 rst_n = 1'b0;

        // Reset values held for three cycles, then in_ready after release.
        ticks(3);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_cnt, 0);
        check("rst_fu", {fu_a, fu_b, fu_c}, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // Single operation with exact latency.
        run_op(4'b1010, 4'b0100, 4'b0111);
        check("single_fu", {fu_a, fu_b, fu_c}, 12'b1010_0100_0111);
        check("single_busy", busy, 1);
        check("single_in_ready", in_ready, 0);
        ticks(2);
        check("single_early_valid", out_valid, 0);
        tick();
        check("single_valid", out_valid, 1);
        check("single_y", out_y, 4'b1001);
        check("single_idle", busy, 0);
        pop_one();
        check("single_popped", out_valid, 0);
        check("single_done", done_cnt, exp_done);

        // Table of vectors, each as one full operation.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c);
            ticks(SETTLE + 1);
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_y", i), out_y, vecs[i].y);
            pop_one();
            check($sformatf("vec%0d_done", i), done_cnt, exp_done);
        end

        // Backpressure: fill the buffer, hold head, then drain in order.
        run_op(4'b1010, 4'b0100, 4'b0111);
        ticks(SETTLE + 1);
        check("bp_first_valid", out_valid, 1);
        run_op(4'b1010, 4'b0100, 4'b1100);
        ticks(SETTLE + 1);
        check("bp_full_in_ready", in_ready, 0);
        check("bp_held_y", out_y, 4'b1001);
        in_valid = 1'b1;
        in_a = 4'b1111;
        in_b = 4'b1111;
        in_c = 4'b0001;
        ticks(2);
        check("bp_still_full", in_ready, 0);
        check("bp_fu_held", {fu_a, fu_b, fu_c}, 12'b1010_0100_1100);
        check("bp_idle", busy, 0);
        check("bp_still_y", out_y, 4'b1001);
        in_valid = 1'b0;
        pop_one();
        check("bp_second_valid", out_valid, 1);
        check("bp_second_y", out_y, 4'b0010);
        pop_one();
        check("bp_drained", out_valid, 0);
        check("bp_done", done_cnt, exp_done);

        // Push and pop on the same edge.
        run_op(4'b0001, 4'b0010, 4'b0100);
        ticks(SETTLE + 1);
        run_op(4'b1111, 4'b0000, 4'b0101);
        ticks(SETTLE);
        check("pp_head_before", out_y, 4'b0111);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_done++;
        check("pp_valid", out_valid, 1);
        check("pp_new_y", out_y, 4'b1010);
        check("pp_count_one", in_ready, 1);
        pop_one();
        check("pp_empty", out_valid, 0);
        check("pp_done", done_cnt, exp_done);

        // Reset in the middle of SETTLE.
        run_op(4'b1010, 4'b0100, 4'b0111);
        tick();
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_fu", {fu_a, fu_b, fu_c}, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_done", done_cnt, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        ticks(2);
        rst_n = 1'b1;
        exp_done = '0;
        ticks(4);
        check("mid_no_late_push", out_valid, 0);
        check("mid_idle", busy, 0);

        // 256 operations bring done_cnt back around to zero.
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            run_op(W'($urandom), W'($urandom), W'($urandom));
            out_ready = 1'b1;
            ticks(SETTLE + 2);
            if (i == 254) check("wrap_255", done_cnt, 255);
        end
        out_ready = 1'b0;
        check("wrap_zero", done_cnt, 0);
        check("wrap_empty", out_valid, 0);

        // Randomized traffic against a latency-level reference model.
        do_reset();
        m_q.delete();
        m_inflight = 0;
        m_rem = 0;
        m_a = '0;
        m_b = '0;
        m_c = '0;
        m_y = '0;
        m_done = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            bit exp_rdy;
            bit do_pop;
            bit do_acc;
            exp_rdy = !m_inflight && (m_q.size() < DEPTH);
            check("rnd_in_ready", in_ready, exp_rdy);
            check("rnd_busy", busy, m_inflight);
            check("rnd_out_valid", out_valid, m_q.size() > 0);
            check("rnd_done", done_cnt, m_done);
            check("rnd_fu", {fu_a, fu_b, fu_c}, {m_a, m_b, m_c});
            if (m_q.size() > 0) check("rnd_out_y", out_y, m_q[0]);

            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_c      = W'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            do_pop = (m_q.size() > 0) && out_ready;
            do_acc = exp_rdy && in_valid;
            tick();
            if (do_pop) begin
                void'(m_q.pop_front());
                m_done++;
            end
            if (m_inflight) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_q.push_back(m_y);
                    m_inflight = 0;
                end
            end
            if (do_acc) begin
                m_a = in_a;
                m_b = in_b;
                m_c = in_c;
                m_y = in_a ^ in_b ^ in_c;
                m_inflight = 1;
                m_rem = SETTLE + 1;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/op3_sequencer.md
OP3_SEQUENCER -- requirements
Module: op3_sequencer

Interface
REQ-001 Parameter DATA_W, default 4: width of each operand and of the result.
REQ-002 Parameter SETTLE_CYC, default 2, legal range 1..15: cycles operands are held on fu_* before fu_y is sampled.
REQ-003 Parameter FIFO_DEPTH, default 2: result buffer entries.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  operand triple offered.
REQ-007 in_ready  out  1  sequencer accepts the triple this cycle.
REQ-008 in_a, in_b, in_c  in  DATA_W each  operand triple.
REQ-009 fu_a, fu_b, fu_c  out  DATA_W each  registered operands driven to the external 3-input combinational function unit.
REQ-010 fu_y  in  DATA_W  function unit result.
REQ-011 out_valid  out  1  result buffer non-empty.
REQ-012 out_ready  in  1  consumer takes the head result.
REQ-013 out_y  out  DATA_W  head-of-buffer result.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done_cnt  out  8  count of results delivered to the consumer.

Function
REQ-016 FSM states IDLE, SETTLE, CAPTURE; one operation in flight at a time.
REQ-017 in_ready = (state==IDLE) and buffer count < FIFO_DEPTH and rst_n high.
REQ-018 Accept on the edge where in_valid and in_ready: load in_a/b/c into fu_a/b/c, load settle counter with SETTLE_CYC-1, go SETTLE.
REQ-019 SETTLE: counter decrements each cycle; on the edge where it is 0, go CAPTURE.
REQ-020 CAPTURE: for exactly one cycle; at its closing edge push fu_y into the buffer and go IDLE.
REQ-021 Latency: accept at edge T -> push at edge T+SETTLE_CYC+1; out_valid high after that edge if buffer was empty.
REQ-022 fu_a/b/c hold their last operands between operations; change only on accept or reset.
REQ-023 Buffer is FIFO-ordered; pop on out_valid and out_ready; out_y and out_valid stable while out_valid and not out_ready.
REQ-024 Push and pop on the same edge: count unchanged, order preserved, no data loss.
REQ-025 Push into a full buffer cannot occur (guaranteed by REQ-017); pop from empty is ignored.
REQ-026 Pointers wrap modulo FIFO_DEPTH.
REQ-027 done_cnt increments by 1 per pop, wraps 255 -> 0.
REQ-028 in_valid deasserted without acceptance: no state change.

Reset
REQ-029 While rst_n low: state IDLE, fu_a/b/c = 0, out_valid = 0, out_y = 0, busy = 0, in_ready = 0, done_cnt = 0, buffer empty.
REQ-030 Reset asserted mid-operation aborts it immediately; in-flight operands and all buffered results are discarded.
REQ-031 First cycle after rst_n rises: in_ready = 1.

Structure
REQ-032 Shared package op3_pkg holds the FSM state enum, DATA_W default and the done_cnt width constant.
REQ-033 Result buffer is one sub-module, op3_result_fifo (parameterised DATA_W, FIFO_DEPTH; push, pop, full, empty, count).
REQ-034 The function unit is external; the sequencer contains no result logic of its own.

Verification (bench FU model: y = a ^ b ^ c, SETTLE_CYC = 2)
REQ-035 Reset: rst_n low for 3 cycles -> all outputs 0, in_ready 0; release -> in_ready 1 next cycle.
REQ-036 Single op: accept (1010,0100,0111) at edge T -> fu_* = 1010/0100/0111 after T, busy high, out_valid after T+3 with out_y = 1001, done_cnt 1 after pop.
REQ-037 Backpressure: out_ready 0, ops (1010,0100,0111) then (1010,0100,1100) -> buffer full, in_ready 0, out_y held 1001; pop -> out_y 0010 next, then out_valid 0.
REQ-038 Simultaneous push/pop: one entry buffered, out_ready 1 on the CAPTURE edge -> count stays 1, out_y becomes new result.
REQ-039 Reset mid-SETTLE -> out_valid 0, fu_* 0000, done_cnt 0, no late push.
REQ-040 256 accepted and popped ops -> done_cnt returns to 0.
